// File: rtl/enc_mac_arbiter_pkg.sv
// Shared definitions for the two-requester encoder MAC arbiter: FSM encoding,
// requester ids and the default fixed-point fraction width.
package enc_mac_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic ReqId0 = 1'b0;
  localparam logic ReqId1 = 1'b1;

  localparam int unsigned DefaultFrac = 8;

endpackage

// File: rtl/enc_mac_lane.sv
// One MAC lane: signed fixed-point multiply (truncating) plus wrapping accumulate,
// with a bias preload at grant time.
module enc_mac_lane
  import enc_mac_arbiter_pkg::*;
#(
  parameter int unsigned Bitsize = 16,
  parameter int unsigned Frac    = DefaultFrac
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [Bitsize-1:0] bias_i,
  input  logic [Bitsize-1:0] a_i,
  input  logic [Bitsize-1:0] b_i,
  output logic [Bitsize-1:0] acc_o
);

  // Full-width signed product, arithmetic shift by Frac, keep the low word.
  function automatic logic [Bitsize-1:0] fixed_point_multiply(input logic [Bitsize-1:0] a,
                                                              input logic [Bitsize-1:0] b);
    logic signed [2*Bitsize-1:0] a_ext;
    logic signed [2*Bitsize-1:0] b_ext;
    logic signed [2*Bitsize-1:0] prod;
    logic signed [2*Bitsize-1:0] shifted;
    a_ext   = $signed({{Bitsize{a[Bitsize-1]}}, a});
    b_ext   = $signed({{Bitsize{b[Bitsize-1]}}, b});
    prod    = a_ext * b_ext;
    shifted = prod >>> Frac;
    return shifted[Bitsize-1:0];
  endfunction

  function automatic logic [Bitsize-1:0] fixed_point_add(input logic [Bitsize-1:0] a,
                                                         input logic [Bitsize-1:0] b);
    return a + b;
  endfunction

  logic [Bitsize-1:0] acc_q;
  logic [Bitsize-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = bias_i;
    end else if (en_i) begin
      acc_d = fixed_point_add(acc_q, fixed_point_multiply(a_i, b_i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/enc_mac_arbiter.sv
// Round-robin sharing of an NOut-lane MAC array between two requesters; each grant
// computes y = W*x + b over NIn cycles and publishes a registered result.
module enc_mac_arbiter
  import enc_mac_arbiter_pkg::*;
#(
  parameter int unsigned Bitsize = 16,
  parameter int unsigned NIn     = 6,
  parameter int unsigned NOut    = 2,
  parameter int unsigned Frac    = DefaultFrac
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req0_i,
  input  logic [Bitsize*NIn-1:0]       x0_i,
  input  logic [Bitsize*NOut*NIn-1:0]  w0_i,
  input  logic [Bitsize*NOut-1:0]      b0_i,
  input  logic                         req1_i,
  input  logic [Bitsize*NIn-1:0]       x1_i,
  input  logic [Bitsize*NOut*NIn-1:0]  w1_i,
  input  logic [Bitsize*NOut-1:0]      b1_i,
  output logic                         gnt0_o,
  output logic                         gnt1_o,
  output logic                         done0_o,
  output logic                         done1_o,
  output logic [Bitsize*NOut-1:0]      y_o,
  output logic                         y_owner_o,
  output logic                         busy_o
);

  localparam int unsigned KW = 4;
  localparam logic [KW-1:0] KLast = KW'(NIn - 1);

  state_e                    state_q;
  logic [KW-1:0]             k_q;
  logic                      id_q;
  logic                      last_q;
  logic                      gnt0_q, gnt1_q;
  logic                      done0_q, done1_q;
  logic [Bitsize*NOut-1:0]   y_q;
  logic                      y_owner_q;

  logic                      elig0, elig1;
  logic                      grant_valid;
  logic                      grant_id;
  logic [Bitsize*NIn-1:0]    x_sel;
  logic [Bitsize*NOut*NIn-1:0] w_sel;
  logic [Bitsize*NOut-1:0]   b_sel;
  logic [Bitsize-1:0]        x_k;
  logic [Bitsize*NOut-1:0]   acc_flat;
  logic                      lane_en;

  // A requester whose done pulse is still high is masked so the other side gets a turn.
  always_comb begin
    elig0       = req0_i & ~done0_q;
    elig1       = req1_i & ~done1_q;
    grant_valid = (state_q == StIdle) & (elig0 | elig1);
    grant_id    = (elig0 & elig1) ? ~last_q : elig1;
  end

  // Operands are taken live from the owner's ports; the requester holds them while granted.
  always_comb begin
    x_sel = (id_q == ReqId1) ? x1_i : x0_i;
    w_sel = (id_q == ReqId1) ? w1_i : w0_i;
    b_sel = (grant_id == ReqId1) ? b1_i : b0_i;
    x_k   = x_sel[Bitsize*k_q +: Bitsize];
  end

  assign lane_en = (state_q == StMac);

  for (genvar i = 0; i < NOut; i++) begin : g_lane
    logic [Bitsize-1:0] w_ki;
    assign w_ki = w_sel[Bitsize*NOut*k_q + Bitsize*i +: Bitsize];

    enc_mac_lane #(
      .Bitsize(Bitsize),
      .Frac   (Frac)
    ) u_lane (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load_i(grant_valid),
      .en_i  (lane_en),
      .bias_i(b_sel[Bitsize*i +: Bitsize]),
      .a_i   (x_k),
      .b_i   (w_ki),
      .acc_o (acc_flat[Bitsize*i +: Bitsize])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      k_q       <= '0;
      id_q      <= ReqId0;
      last_q    <= ReqId1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      y_q       <= '0;
      y_owner_q <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            state_q <= StMac;
            k_q     <= '0;
            id_q    <= grant_id;
            last_q  <= grant_id;
            gnt0_q  <= (grant_id == ReqId0);
            gnt1_q  <= (grant_id == ReqId1);
          end
        end
        StMac: begin
          k_q <= k_q + 1'b1;
          if (k_q == KLast) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          y_q       <= acc_flat;
          y_owner_q <= id_q;
          done0_q   <= (id_q == ReqId0);
          done1_q   <= (id_q == ReqId1);
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign done0_o   = done0_q;
  assign done1_o   = done1_q;
  assign y_o       = y_q;
  assign y_owner_o = y_owner_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_enc_mac_arbiter.sv
// Scoreboard bench for enc_mac_arbiter: expected {owner, y} pushed at request time,
// popped and compared on each done pulse.
module tb_enc_mac_arbiter;

  localparam int BW   = 16;
  localparam int NIN  = 6;
  localparam int NOUT = 2;
  localparam int FRAC = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   req0, req1;
  logic [BW*NIN-1:0]      x0, x1;
  logic [BW*NOUT*NIN-1:0] w0, w1;
  logic [BW*NOUT-1:0]     b0, b1;
  logic                   gnt0, gnt1, done0, done1, y_owner, busy;
  logic [BW*NOUT-1:0]     y;

  int n_total = 0;
  int n_bad   = 0;
  logic [BW*NOUT:0] exp_q[$];

  enc_mac_arbiter #(
    .Bitsize(BW),
    .NIn    (NIN),
    .NOut   (NOUT),
    .Frac   (FRAC)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req0_i   (req0),
    .x0_i     (x0),
    .w0_i     (w0),
    .b0_i     (b0),
    .req1_i   (req1),
    .x1_i     (x1),
    .w1_i     (w1),
    .b1_i     (b1),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .done0_o  (done0),
    .done1_o  (done1),
    .y_o      (y),
    .y_owner_o(y_owner),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW*NIN-1:0] fill_x(input logic [BW-1:0] v);
    logic [BW*NIN-1:0] r;
    for (int k = 0; k < NIN; k++) r[BW*k +: BW] = v;
    return r;
  endfunction

  function automatic logic [BW*NOUT*NIN-1:0] fill_w(input logic [BW-1:0] v);
    logic [BW*NOUT*NIN-1:0] r;
    for (int k = 0; k < NOUT*NIN; k++) r[BW*k +: BW] = v;
    return r;
  endfunction

  // Reference y = W*x + b with truncating Q-format product and wrapping sum.
  function automatic logic [BW*NOUT-1:0] model_y(input logic [BW*NIN-1:0] x,
                                                 input logic [BW*NOUT*NIN-1:0] w,
                                                 input logic [BW*NOUT-1:0] b);
    logic [BW*NOUT-1:0] r;
    logic [BW-1:0] acc;
    logic signed [BW-1:0] xs, ws;
    logic signed [2*BW-1:0] p;
    for (int i = 0; i < NOUT; i++) begin
      acc = b[BW*i +: BW];
      for (int k = 0; k < NIN; k++) begin
        xs  = x[BW*k +: BW];
        ws  = w[BW*NOUT*k + BW*i +: BW];
        p   = xs * ws;
        p   = p >>> FRAC;
        acc = acc + p[BW-1:0];
      end
      r[BW*i +: BW] = acc;
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input logic id, input int budget, output int cycles);
    cycles = 0;
    while (((id ? done1 : done0) !== 1'b1) && (cycles < budget)) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= budget) check_eq("done_timeout", {done1, done0}, id ? 2'b10 : 2'b01);
  endtask

  // Invariants every cycle, and scoreboard pop on each done pulse.
  always @(negedge clk) begin
    logic [BW*NOUT:0] e;
    if (rst_n) begin
      check_eq("gnt_excl", gnt0 & gnt1, 0);
      check_eq("done_excl", done0 & done1, 0);
      if (done0 | done1) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", {done1, done0}, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("y", y, e[BW*NOUT-1:0]);
          check_eq("y_owner", y_owner, e[BW*NOUT]);
          check_eq("done_id", done1, e[BW*NOUT]);
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    x0 = '0; w0 = '0; b0 = '0;
    x1 = '0; w1 = '0; b1 = '0;
    repeat (2) tick();
    check_eq("rst_gnt", {gnt1, gnt0}, 0);
    check_eq("rst_done", {done1, done0}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_owner", y_owner, 0);
    rst_n = 1'b1;
    tick();

    // Single request, latency
    x0 = fill_x(16'h0100);
    w0 = fill_w(16'h0100);
    b0 = '0;
    exp_q.push_back({1'b0, 32'h0600_0600});
    req0 = 1'b1;
    tick();
    check_eq("t1_gnt0", gnt0, 1);
    check_eq("t1_gnt1", gnt1, 0);
    check_eq("t1_busy", busy, 1);
    wait_done(1'b0, 30, c);
    check_eq("t1_latency", c, 7);
    check_eq("t1_gnt0_at_done", gnt0, 0);
    req0 = 1'b0;
    tick();
    check_eq("t1_idle", {busy, gnt1, gnt0}, 0);
    tick();
    check_eq("t1_no_regrant", {busy, gnt0}, 0);
    check_eq("t1_y_hold", y, 32'h0600_0600);

    // Tie after reset, then a later tie
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    x1 = '0;
    x1[BW-1:0] = 16'hFF00;
    w1 = fill_w(16'h0200);
    b1 = {16'h0000, 16'h0080};
    exp_q.push_back({1'b0, 32'h0600_0600});
    exp_q.push_back({1'b1, 32'hFE00_FE80});
    exp_q.push_back({1'b0, 32'h0600_0600});
    exp_q.push_back({1'b1, 32'hFE00_FE80});
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    check_eq("t2_first_winner", {gnt1, gnt0}, 2'b01);
    wait_done(1'b0, 30, c);
    tick();
    check_eq("t2_gnt1_after_done0", {gnt1, gnt0}, 2'b10);
    wait_done(1'b1, 30, c);
    check_eq("t2_latency1", c, 7);
    tick();
    check_eq("t2_back_to_0", {gnt1, gnt0}, 2'b01);
    wait_done(1'b0, 30, c);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check_eq("t2_idle", busy, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    check_eq("t2_second_tie", {gnt1, gnt0}, 2'b10);
    wait_done(1'b1, 30, c);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // Wrap-around accumulation
    x0 = fill_x(16'h7F00);
    w0 = fill_w(16'h0100);
    b0 = '0;
    exp_q.push_back({1'b0, 32'hFA00_FA00});
    req0 = 1'b1;
    wait_done(1'b0, 30, c);
    req0 = 1'b0;
    tick();

    // Request dropped mid-operation (random operands)
    for (int k = 0; k < NIN; k++) x1[BW*k +: BW] = 16'($urandom);
    for (int k = 0; k < NIN*NOUT; k++) w1[BW*k +: BW] = 16'($urandom);
    b1 = 32'($urandom);
    exp_q.push_back({1'b1, model_y(x1, w1, b1)});
    req1 = 1'b1;
    tick();
    check_eq("t4_gnt1", gnt1, 1);
    repeat (2) tick();
    req1 = 1'b0;
    wait_done(1'b1, 30, c);
    repeat (2) tick();
    check_eq("t4_no_regrant", {busy, gnt1, gnt0}, 0);

    // Reset asserted mid-MAC
    x0 = fill_x(16'h0100);
    w0 = fill_w(16'h0100);
    b0 = '0;
    req0 = 1'b1;
    tick();
    check_eq("t5_gnt0", gnt0, 1);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    req1 = 1'b1;
    #1;
    check_eq("t5_rst_gnt", {gnt1, gnt0}, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_y", y, 0);
    check_eq("t5_rst_owner", y_owner, 0);
    tick();
    exp_q.push_back({1'b0, 32'h0600_0600});
    rst_n = 1'b1;
    tick();
    check_eq("t5_first_after_rst", {gnt1, gnt0}, 2'b01);
    wait_done(1'b0, 30, c);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();
    check_eq("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
